truth_table_checker: RTL and testbench
======================================

# truth_table_checker

- Self-checking response block for 3-input combinational gate experiments. It is the checking end of the sweep that the gate benches apply by hand.
- On `start`, it drives every input combination 0 to 2^N_IN-1 onto the gate under test. It waits a programmable settle time, then samples the gate output against an expected truth table.
- It reports pass/fail, a mismatch count and the first failing index.
- It sits between the lab board switches/LEDs and the gate module under test.

## Interface
- `N_IN`, default 3: number of gate inputs; the sweep covers 2^N_IN vectors.
- `SETTLE`, default 2: extra cycles each vector is held before sampling (0..15).
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- `exp_tt`  input  2^N_IN: expected output; bit i = expected `dut_z` when `dut_in` = i. Sampled once at `start` into an internal register.
- `dut_in`  output  N_IN: vector driven to the gate under test; MSB = input a.
- `dut_z`  input  1: gate output being checked.
- `busy`  output  1: high while a sweep is in progress.
- `done`  output  1: one-cycle pulse when the sweep completes.
- `pass`  output  1: high after a completed sweep with zero mismatches; held until the next `start`.
- `err_count`  output  N_IN+1: number of mismatching vectors in the last sweep (0..2^N_IN).
- `fail_valid`  output  1: high once at least one mismatch has been recorded in the current or last sweep.
- `first_fail`  output  N_IN: index of the first mismatching vector; valid only when `fail_valid`.
- `fail_map`  output  2^N_IN: per-vector mismatch bitmap (see Configuration).

## Operation
- FSM states are IDLE, DRIVE, SAMPLE, DONE.
- **Reset:** all outputs are 0 and the state is IDLE.
- **IDLE/DONE + `start`:**
  - Capture `exp_tt`.
  - Clear `err_count`, `fail_valid`, `first_fail`, `fail_map` and `pass`.
  - Set `dut_in` to 0 and `busy` to 1, with the settle counter at 0.
  - Go to DRIVE.
- **DRIVE:** increment the settle counter each cycle. When the counter equals `SETTLE`, go to SAMPLE. With `SETTLE` = 0, DRIVE lasts exactly one cycle.
- **SAMPLE (one cycle):**
  - Compare `dut_z` against captured bit `dut_in`.
  - On mismatch:
    - Increment `err_count`.
    - Set `fail_map[dut_in]`.
    - If `fail_valid` is 0, load `first_fail` = `dut_in` and set `fail_valid`.
  - If `dut_in` = 2^N_IN-1, go to DONE.
  - Otherwise increment `dut_in`, clear the settle counter and return to DRIVE.
- **DONE:**
  - `busy` = 0.
  - `done` pulses for the entry cycle only.
  - `pass` = (`err_count` == 0).
  - `dut_in` holds its last value.
  - Results hold until the next `start`.
- **Boundary conditions:**
  - `start` while `busy` is ignored, and the sweep continues unchanged.
  - Changes to `exp_tt` during a sweep have no effect.
  - `err_count` saturation is not needed: its width holds 2^N_IN exactly.
  - `dut_in` does not wrap; the sweep ends at all-ones.
  - `rst_n` asserted mid-sweep forces IDLE and all-zero outputs immediately, with no `done` pulse.

## Timing
- `start` sampled high at edge T gives `busy`=1 and `dut_in`=0 after T.
- Each vector is held for `SETTLE`+2 cycles: `SETTLE`+1 in DRIVE, then 1 in SAMPLE.
- `dut_z` is compared at the edge ending the SAMPLE cycle.
- `done` is high in cycle T + 2^N_IN·(`SETTLE`+2) + 1 relative to the `start` edge. For defaults this is 8·4+1 = 33 cycles after `start`.
- `busy` falls in the same cycle that `done` rises.
- Outputs are registered; none depends combinationally on `dut_z` or `start`.

## Configuration
- `TT_CHECK_FAIL_MAP_EN` defined: `fail_map` is a register, set per mismatching vector and cleared on `start`.
- `TT_CHECK_FAIL_MAP_EN` undefined: `fail_map` is tied to 0. No bitmap flops are built. All other behaviour is identical.

## Test plan
- **Correct gate:**
  - Stimulus: z = a&b | c; `exp_tt` = 8'hEA; `start`.
  - Response: `done` at cycle 33, `pass`=1, `err_count`=0, `fail_valid`=0, `dut_in` sequence 0..7 with each held 4 cycles.
- **Stuck-at-0 output:**
  - Stimulus: `dut_z` tied 0; `exp_tt` = 8'hEA.
  - Response: `pass`=0, `err_count`=5, `first_fail`=1, `fail_map`=8'hEA when the macro is defined (0 when undefined).
- **Single wrong entry:**
  - Stimulus: gate z = a&b | c except vector 6 is driven 0; `exp_tt` = 8'hEA.
  - Response: `err_count`=1, `first_fail`=6, `fail_map`=8'h40.
- **Start while busy:**
  - Stimulus: pulse `start` again at cycle 10 of a sweep.
  - Response: no restart, `done` still at cycle 33, and counts unaffected.
- **Reset mid-sweep:**
  - Stimulus: drop `rst_n` at cycle 15, release it, then issue a new `start`.
  - Response: all outputs 0 immediately with no `done`; the fresh sweep gives the correct results.
- **SETTLE = 0:**
  - Stimulus: `SETTLE` = 0 with a correct gate.
  - Response: each vector held 2 cycles, `done` at cycle 17, `pass`=1.

Source files
------------

// File: rtl/truth_table_checker.sv
// Sweeps every input vector onto a gate under test, waits SETTLE extra cycles per
// vector, and scores dut_z against a captured truth table. Option: TT_CHECK_FAIL_MAP_EN.
module truth_table_checker #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   exp_tt,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_z,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic                   fail_valid,
  output logic [N_IN-1:0]        first_fail,
  output logic [(1<<N_IN)-1:0]   fail_map
);

  localparam int NV = 1 << N_IN;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [NV-1:0]   tt_q;
  logic [3:0]      settle_cnt;
  logic            mismatch;
  logic            last_vec;
  logic            start_ok;

  assign mismatch = dut_z ^ tt_q[dut_in];
  assign last_vec = &dut_in;
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = DRIVE;
      DRIVE:      if (settle_cnt == 4'(SETTLE)) state_next = SAMPLE;
      SAMPLE:     state_next = last_vec ? DONE : DRIVE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DRIVE) || (state == SAMPLE);
  end

  // The final SAMPLE also settles pass, folding in that cycle's own mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q       <= '0;
      settle_cnt <= '0;
      dut_in     <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        tt_q       <= exp_tt;
        settle_cnt <= '0;
        dut_in     <= '0;
        err_count  <= '0;
        fail_valid <= 1'b0;
        first_fail <= '0;
        pass       <= 1'b0;
      end else begin
        case (state)
          DRIVE: settle_cnt <= settle_cnt + 4'd1;
          SAMPLE: begin
            if (mismatch) begin
              err_count <= err_count + (N_IN+1)'(1);
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                first_fail <= dut_in;
              end
            end
            if (last_vec) begin
              done <= 1'b1;
              pass <= (err_count == '0) && !mismatch;
            end else begin
              dut_in     <= dut_in + N_IN'(1);
              settle_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TT_CHECK_FAIL_MAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          fail_map <= '0;
    else if (start_ok)                   fail_map <= '0;
    else if (state == SAMPLE && mismatch) fail_map[dut_in] <= 1'b1;
  end
`else
  assign fail_map = '0;
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench for truth_table_checker: a SETTLE=2 and a SETTLE=0 instance
// checked against hand-computed sweep results.
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         failures = 0;
  int         edge_n = 0;

  // Instance a: SETTLE=2, instance b: SETTLE=0
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] tt_a = '0, tt_b = '0;
  logic [2:0] dut_in_a, dut_in_b;
  logic       z_a, z_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [3:0] err_a, err_b;
  logic       fv_a, fv_b;
  logic [2:0] ff_a, ff_b;
  logic [7:0] map_a, map_b;
  int         mode_a = 0, mode_b = 0;

  // Packed result: {done_cycle[7:0], pass, fail_valid, first_fail[2:0], err_count[3:0], fail_map[7:0]}
  logic [24:0] exp_qa[$];
  logic [24:0] exp_qb[$];

  truth_table_checker #(.N_IN(3), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .exp_tt(tt_a), .dut_in(dut_in_a),
    .dut_z(z_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_valid(fv_a), .first_fail(ff_a), .fail_map(map_a)
  );

  truth_table_checker #(.N_IN(3), .SETTLE(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .exp_tt(tt_b), .dut_in(dut_in_b),
    .dut_z(z_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .fail_valid(fv_b), .first_fail(ff_b), .fail_map(map_b)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Gate under test: z = a&b | c, with fault modes 1 stuck-0, 2 vector 6 wrong, 3 stuck-1
  function automatic logic gate(input logic [2:0] v, input int m);
    logic z;
    z = (v[2] & v[1]) | v[0];
    case (m)
      1:       return 1'b0;
      2:       return (v == 3'd6) ? 1'b0 : z;
      3:       return 1'b1;
      default: return z;
    endcase
  endfunction

  always_comb z_a = gate(dut_in_a, mode_a);
  always_comb z_b = gate(dut_in_b, mode_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] pack(input int cyc, input logic p, input logic fv,
                                       input logic [2:0] ff, input logic [3:0] ec,
                                       input logic [7:0] map);
    logic [7:0] m;
`ifdef TT_CHECK_FAIL_MAP_EN
    m = map;
`else
    m = 8'h00;
`endif
    return {8'(cyc), p, fv, ff, ec, m};
  endfunction

  // Monitors: dut_in sequence while busy, full result on each done pulse
  int   t_a = 0, t_b = 0;
  logic pb_a = 1'b0, pb_b = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy_a && !pb_a) t_a = edge_n;
      if (busy_a) check("dut_in_seq_a", 32'(dut_in_a), 32'((edge_n - t_a) / 4));
      if (done_a) begin
        check("busy_low_at_done_a", 32'(busy_a), 32'd0);
        check("dut_in_hold_a", 32'(dut_in_a), 32'd7);
        if (exp_qa.size() == 0) check("unexpected_done_a", 32'd1, 32'd0);
        else check("result_a", 32'({8'(edge_n - t_a + 1), pass_a, fv_a, ff_a, err_a, map_a}),
                   32'(exp_qa.pop_front()));
      end
    end
    pb_a = busy_a;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy_b && !pb_b) t_b = edge_n;
      if (busy_b) check("dut_in_seq_b", 32'(dut_in_b), 32'((edge_n - t_b) / 2));
      if (done_b) begin
        check("busy_low_at_done_b", 32'(busy_b), 32'd0);
        if (exp_qb.size() == 0) check("unexpected_done_b", 32'd1, 32'd0);
        else check("result_b", 32'({8'(edge_n - t_b + 1), pass_b, fv_b, ff_b, err_b, map_b}),
                   32'(exp_qb.pop_front()));
      end
    end
    pb_b = busy_b;
  end

  // driver tasks
  task automatic start_sweep(input bit on_b, input logic [7:0] tt, input int mode,
                             input bit push, input logic [24:0] exp);
    @(negedge clk);
    if (on_b) begin
      tt_b = tt; mode_b = mode; start_b = 1'b1;
      if (push) exp_qb.push_back(exp);
    end else begin
      tt_a = tt; mode_a = mode; start_a = 1'b1;
      if (push) exp_qa.push_back(exp);
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 300 && (exp_qa.size() != 0 || exp_qb.size() != 0); i++) @(negedge clk);
    check("sweep_timeout", 32'(exp_qa.size() + exp_qb.size()), 32'd0);
    exp_qa.delete();
    exp_qb.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs_a", 32'({busy_a, done_a, pass_a, err_a, fv_a, ff_a, map_a, dut_in_a}), 32'd0);
    check("reset_outputs_b", 32'({busy_b, done_b, pass_b, err_b, fv_b, ff_b, map_b, dut_in_b}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // correct gate
    start_sweep(1'b0, 8'hEA, 0, 1'b1, pack(33, 1'b1, 1'b0, 3'd0, 4'd0, 8'h00));
    wait_empty();
    // stuck-at-0 output
    start_sweep(1'b0, 8'hEA, 1, 1'b1, pack(33, 1'b0, 1'b1, 3'd1, 4'd5, 8'hEA));
    wait_empty();
    // vector 6 wrong
    start_sweep(1'b0, 8'hEA, 2, 1'b1, pack(33, 1'b0, 1'b1, 3'd6, 4'd1, 8'h40));
    wait_empty();

    // start while busy plus exp_tt change mid-sweep: neither may disturb the sweep
    start_sweep(1'b0, 8'hEA, 0, 1'b1, pack(33, 1'b1, 1'b0, 3'd0, 4'd0, 8'h00));
    repeat (8) @(negedge clk);
    start_a = 1'b1;
    tt_a = 8'h00;
    @(negedge clk);
    start_a = 1'b0;
    wait_empty();

    // reset mid-sweep: outputs clear at once and no done appears
    start_sweep(1'b0, 8'hEA, 0, 1'b0, '0);
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midsweep_reset_outputs",
          32'({busy_a, done_a, pass_a, err_a, fv_a, ff_a, map_a, dut_in_a}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    start_sweep(1'b0, 8'hEA, 2, 1'b1, pack(33, 1'b0, 1'b1, 3'd6, 4'd1, 8'h40));
    wait_empty();

    // SETTLE = 0 instance
    start_sweep(1'b1, 8'hEA, 0, 1'b1, pack(17, 1'b1, 1'b0, 3'd0, 4'd0, 8'h00));
    wait_empty();
    start_sweep(1'b1, 8'hEA, 3, 1'b1, pack(17, 1'b0, 1'b1, 3'd0, 4'd3, 8'h15));
    wait_empty();
    check("pass_held_b", 32'(pass_b), 32'd0);
    check("err_held_b", 32'(err_b), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
